// File: rtl/multiplier_control_if.sv
// Control-strobe bundle between the multiply sequencer and the shift-add datapath / user inputs.
// The master modport is the sequencer; the slave side drives the user requests and B[0].
interface multiplier_control_if;
  logic run;
  logic clr_ld;
  logic m;
  logic shift_sig;
  logic add_sig;
  logic sub_sig;
  logic clear_A_load_B_sig;
  logic XA_clr;
  logic busy;
  logic done;

  modport master (
    input  run, clr_ld, m,
    output shift_sig, add_sig, sub_sig, clear_A_load_B_sig, XA_clr, busy, done
  );

  modport slave (
    output run, clr_ld, m,
    input  shift_sig, add_sig, sub_sig, clear_A_load_B_sig, XA_clr, busy, done
  );
endinterface

// File: rtl/multiplier_control.sv
// Sequencer for the signed shift-add multiplier: synchronizes the run and clr_ld presses,
// then issues XA clear followed by N_BITS arithmetic/shift pairs (last pair subtracts).
module multiplier_control #(
  parameter int N_BITS      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  multiplier_control_if.master bus
);
  localparam int            CW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  typedef enum logic [2:0] {IDLE, CLR_XA, ARITH, SHIFT, DONE} state_t;

  // Lane 0 is run, lane 1 is clr_ld.
  logic [1:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]                  hist_q, hist_d;
  logic [SYNC_STAGES-1:0]      vld_pipe_q, vld_pipe_d;
  logic [1:0]                  edge_s;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          xa_clr_q, xa_clr_d;
  logic          shift_q, shift_d;
  logic          arith_q, arith_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  assign raw = {bus.clr_ld, bus.run};

  // History only starts following the synchronizer once it holds real samples, so a
  // level held high through reset never looks like a fresh press.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[SYNC_STAGES-2:0], 1'b1};
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      hist_d[i] = vld_pipe_q[SYNC_STAGES-1] ? sync_q[i][SYNC_STAGES-1] : hist_q[i];
      edge_s[i] = vld_pipe_q[SYNC_STAGES-1] & sync_q[i][SYNC_STAGES-1] & ~hist_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (edge_s[1])      state_d = IDLE;
        else if (edge_s[0]) state_d = CLR_XA;
      end
      CLR_XA: begin
        cnt_d   = '0;
        state_d = ARITH;
      end
      ARITH:  state_d = SHIFT;
      SHIFT: begin
        if (cnt_q == LAST) state_d = DONE;
        else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ARITH;
        end
      end
      default: state_d = IDLE;
    endcase
    xa_clr_d = (state_d == CLR_XA);
    shift_d  = (state_d == SHIFT);
    arith_d  = (state_d == ARITH);
    busy_d   = (state_d == CLR_XA) || (state_d == ARITH) || (state_d == SHIFT);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      hist_q     <= '1;
      vld_pipe_q <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      xa_clr_q   <= 1'b0;
      shift_q    <= 1'b0;
      arith_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      vld_pipe_q <= vld_pipe_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      xa_clr_q   <= xa_clr_d;
      shift_q    <= shift_d;
      arith_q    <= arith_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // add/sub are the only Mealy strobes (on m); the load strobe follows a registered edge.
  assign bus.XA_clr             = xa_clr_q;
  assign bus.shift_sig          = shift_q;
  assign bus.add_sig            = arith_q & bus.m & (cnt_q != LAST);
  assign bus.sub_sig            = arith_q & bus.m & (cnt_q == LAST);
  assign bus.clear_A_load_B_sig = ~busy_q & edge_s[1];
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
endmodule
